// File: rtl/ncl_pkg.sv
// Shared dual-rail NCL definitions: rail-pair codes and the capture-stage state set.
package ncl_pkg;

    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_0    = 2'b01;
    localparam logic [1:0] DR_1    = 2'b10;
    localparam logic [1:0] DR_ILL  = 2'b11;

    typedef enum logic [1:0] {
        REQ_NULL,
        REQ_DATA,
        HOLD,
        ERR
    } state_t;

endpackage

// File: rtl/ncl_completion.sv
// Combinational completion detector for a dual-rail vector of PAIRS rail pairs.
module ncl_completion import ncl_pkg::*; #(
    parameter int unsigned PAIRS = 9
) (
    input  logic [2*PAIRS-1:0] dr,
    output logic               is_data,
    output logic               is_null,
    output logic               is_illegal
);

    always_comb begin
        is_data    = 1'b1;
        is_null    = 1'b1;
        is_illegal = 1'b0;
        for (int unsigned i = 0; i < PAIRS; i++) begin
            case (dr[2*i +: 2])
                DR_NULL: is_data = 1'b0;
                DR_0,
                DR_1:    is_null = 1'b0;
                default: begin
                    is_data    = 1'b0;
                    is_null    = 1'b0;
                    is_illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/ncl_flag_capture.sv
// Synchronizes a dual-rail ALU result/overflow, sequences NCL ko, and hands each
// complete DATA wavefront to a synchronous consumer with status flags.
module ncl_flag_capture import ncl_pkg::*; #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*WIDTH-1:0] result_dr,
    input  logic [1:0]         overflow_dr,
    output logic               ko,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_overflow,
    output logic               out_zero,
    output logic               out_negative,
    output logic               err_illegal
);

    localparam int unsigned PAIRS = WIDTH + 1;
    localparam int unsigned DRW   = 2 * PAIRS;

    logic [DRW-1:0]       sync_q [SYNC_STAGES];
    logic [DRW-1:0]       s;
    logic [DRW-1:0]       s_prev;
    logic [SYNC_STAGES:0] primed;
    logic                 stable;
    logic                 is_data;
    logic                 is_null;
    logic                 is_illegal;
    logic [WIDTH-1:0]     s_true;
    logic                 capture;
    state_t               state;
    state_t               state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            s_prev <= '0;
            primed <= '0;
        end else begin
            sync_q[0] <= {overflow_dr, result_dr};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_prev <= s;
            primed <= {primed[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Reset-filled synchronizer contents are not real samples: stability is only
    // trusted once both s and s_prev hold values clocked in from the inputs.
    assign stable = (s == s_prev) && primed[SYNC_STAGES];

    ncl_completion #(
        .PAIRS (PAIRS)
    ) u_completion (
        .dr         (s),
        .is_data    (is_data),
        .is_null    (is_null),
        .is_illegal (is_illegal)
    );

    always_comb begin
        s_true = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s_true[i] = s[2*i+1];
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        ko         = 1'b0;
        out_valid  = 1'b0;
        case (state)
            REQ_NULL: begin
                if (is_null && stable) state_next = REQ_DATA;
            end
            REQ_DATA: begin
                ko = 1'b1;
                if (is_data && stable) begin
                    state_next = HOLD;
                    capture    = 1'b1;
                end
            end
            HOLD: begin
                ko        = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = REQ_NULL;
            end
            ERR:     state_next = ERR;
            default: state_next = REQ_NULL;
        endcase
        if (is_illegal) begin
            state_next = ERR;
            capture    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= REQ_NULL;
            err_illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == ERR) err_illegal <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
            out_negative <= 1'b0;
        end else if (capture) begin
            out_result   <= s_true;
            out_overflow <= s[2*WIDTH+1];
            out_zero     <= (s_true == '0);
            out_negative <= s_true[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_ncl_flag_capture.sv
// Directed bench for ncl_flag_capture with a wavefront-level reference model.
module tb_ncl_flag_capture;

    localparam int W     = 8;
    localparam int SYNC  = 2;
    localparam int PAIRS = W + 1;
    localparam int DRW   = 2 * PAIRS;

    logic           clk = 1'b0;
    logic           rst;
    logic [DRW-1:0] din;
    logic           out_ready;
    logic           ko, out_valid, out_overflow, out_zero, out_negative, err_illegal;
    logic [W-1:0]   out_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ncl_flag_capture #(
        .WIDTH       (W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .result_dr    (din[2*W-1:0]),
        .overflow_dr  (din[DRW-1:2*W]),
        .ko           (ko),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .out_negative (out_negative),
        .err_illegal  (err_illegal)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DRW-1:0] enc(input logic [W-1:0] w, input logic o);
        logic [DRW-1:0] v;
        for (int i = 0; i < W; i++) v[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
        v[DRW-1 -: 2] = o ? 2'b10 : 2'b01;
        return v;
    endfunction

    function automatic int n_code(input logic [DRW-1:0] v, input logic [1:0] code);
        int n = 0;
        for (int i = 0; i < PAIRS; i++) if (v[2*i +: 2] == code) n++;
        return n;
    endfunction

    function automatic logic [W-1:0] word_of(input logic [DRW-1:0] v);
        logic [W-1:0] w;
        for (int i = 0; i < W; i++) w[i] = v[2*i+1];
        return w;
    endfunction

    // Model: decisions at edge n look at the input word sampled SYNC edges
    // earlier and require it to match the word sampled one edge before that.
    // mode: 0 wait for NULL, 1 wait for DATA, 2 holding a word, 3 error.
    int             m_mode;
    int             m_n;
    logic [DRW-1:0] m_hist [0:SYNC+1];
    logic [W-1:0]   m_res;
    logic           m_ovf;
    logic           m_err;

    task automatic m_reset();
        m_mode = 0;
        m_n    = 0;
        m_res  = '0;
        m_ovf  = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic m_step();
        logic [DRW-1:0] seen;
        logic           same;
        for (int j = SYNC + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = din;
        m_n++;
        seen = m_hist[SYNC];
        same = (m_n >= SYNC + 2) && (m_hist[SYNC] == m_hist[SYNC+1]);
        if (m_n >= SYNC + 1 && n_code(seen, 2'b11) > 0) begin
            m_mode = 3;
            m_err  = 1'b1;
        end else if (m_mode == 0) begin
            if (same && n_code(seen, 2'b00) == PAIRS) m_mode = 1;
        end else if (m_mode == 1) begin
            if (same && n_code(seen, 2'b01) + n_code(seen, 2'b10) == PAIRS) begin
                m_mode = 2;
                m_res  = word_of(seen);
                m_ovf  = seen[DRW-1];
            end
        end else if (m_mode == 2) begin
            if (out_ready) m_mode = 0;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cmp_ko",       ko,           (m_mode == 1 || m_mode == 2));
            check("cmp_valid",    out_valid,    (m_mode == 2));
            check("cmp_result",   out_result,   m_res);
            check("cmp_overflow", out_overflow, m_ovf);
            check("cmp_zero",     out_zero,     (m_n > 0 || m_res != '0) ? (m_res == '0 && m_ovf_seen()) : 1'b0);
            check("cmp_negative", out_negative, m_res[W-1]);
            check("cmp_err",      err_illegal,  m_err);
        end
    end

    // out_zero is 0 out of reset and reflects the captured word once anything
    // has been captured; track whether a capture has happened since reset.
    logic m_any_cap;
    initial begin
        m_any_cap = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            #0;
            if (rst) m_any_cap = 1'b0;
            else if (m_mode == 2) m_any_cap = 1'b1;
        end
    end

    function automatic logic m_ovf_seen();
        return m_any_cap;
    endfunction

    task automatic wait_sig(input bit sel, input logic val, input string nm);
        logic cur;
        cur = sel ? out_valid : ko;
        for (int i = 0; i < 20 && cur !== val; i++) begin
            @(negedge clk);
            cur = sel ? out_valid : ko;
        end
        check(nm, cur, val);
    endtask

    task automatic accept_and_null();
        out_ready = 1'b1;
        @(negedge clk);
        check("accept_valid_drop", out_valid, 1'b0);
        check("accept_ko_drop", ko, 1'b0);
        out_ready = 1'b0;
        din = '0;
        wait_sig(1'b0, 1'b1, "ko_after_null");
    endtask

    initial begin
        logic [W-1:0] pw;
        rst = 1'b1;
        din = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ko", ko, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_result", out_result, 8'h00);
        check("rst_err", err_illegal, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("null_wait_ko", ko, 1'b0);
        end
        @(negedge clk);
        check("ko_rise", ko, 1'b1);

        din = enc(8'h80, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("cap_latency_valid", out_valid, 1'b0);
        end
        @(negedge clk);
        check("cap_valid", out_valid, 1'b1);
        check("cap_result", out_result, 8'h80);
        check("cap_overflow", out_overflow, 1'b1);
        check("cap_negative", out_negative, 1'b1);
        check("cap_zero", out_zero, 1'b0);

        din = enc(8'h3C, 1'b0);
        repeat (3) @(negedge clk);
        din = '0;
        repeat (3) @(negedge clk);
        check("hold_valid", out_valid, 1'b1);
        check("hold_result", out_result, 8'h80);
        check("hold_overflow", out_overflow, 1'b1);

        out_ready = 1'b1;
        @(negedge clk);
        check("accept_valid_drop", out_valid, 1'b0);
        check("accept_ko_drop", ko, 1'b0);
        out_ready = 1'b0;
        wait_sig(1'b0, 1'b1, "ko_after_null");
        din = enc(8'h00, 1'b0);
        wait_sig(1'b1, 1'b1, "zero_word_valid");
        check("zero_result", out_result, 8'h00);
        check("zero_flag", out_zero, 1'b1);
        check("zero_overflow", out_overflow, 1'b0);
        check("zero_negative", out_negative, 1'b0);
        accept_and_null();

        pw = 8'hA5;
        din[DRW-1 -: 2] = 2'b01;
        for (int b = 0; b < W; b++) begin
            @(negedge clk);
            check("partial_valid", out_valid, 1'b0);
            check("partial_err", err_illegal, 1'b0);
            din[2*b +: 2] = pw[b] ? 2'b10 : 2'b01;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("partial_latency", out_valid, 1'b0);
        end
        @(negedge clk);
        check("partial_valid_final", out_valid, 1'b1);
        check("partial_result", out_result, 8'hA5);
        check("partial_negative", out_negative, 1'b1);
        accept_and_null();

        din = enc(8'h12, 1'b0);
        din[7:6] = 2'b11;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("ill_err_early", err_illegal, 1'b0);
        end
        @(negedge clk);
        check("ill_err", err_illegal, 1'b1);
        check("ill_ko", ko, 1'b0);
        din = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("err_null_ko", ko, 1'b0);
        end
        din = enc(8'h55, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("err_data_valid", out_valid, 1'b0);
            check("err_sticky", err_illegal, 1'b1);
        end
        rst = 1'b1;
        #1;
        check("err_cleared", err_illegal, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        din = '0;
        wait_sig(1'b0, 1'b1, "post_err_ko");
        din = enc(8'h7F, 1'b0);
        wait_sig(1'b1, 1'b1, "post_err_valid");
        check("post_err_result", out_result, 8'h7F);
        check("post_err_negative", out_negative, 1'b0);

        #2;
        rst = 1'b1;
        #1;
        check("rst_hold_valid", out_valid, 1'b0);
        check("rst_hold_result", out_result, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("stale_valid", out_valid, 1'b0);
            check("stale_ko", ko, 1'b0);
        end
        din = '0;
        wait_sig(1'b0, 1'b1, "stale_null_ko");
        din = enc(8'hC3, 1'b1);
        wait_sig(1'b1, 1'b1, "fresh_valid");
        check("fresh_result", out_result, 8'hC3);
        check("fresh_overflow", out_overflow, 1'b1);
        accept_and_null();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ncl_flag_capture.md
# ncl_flag_capture

Clocked capture stage that sits directly downstream of the dual-rail NCL ALU and its overflow detector. It consumes the dual-rail result word and dual-rail Overflow flag, and drives the NCL acknowledge (ko) that sequences the DATA/NULL wavefronts. On each complete DATA wavefront it presents a single-rail result plus status flags to a synchronous consumer over a valid/ready handshake.

## Interface
Parameters:
- WIDTH, default 8: ALU result width in bits; the dual-rail bus is 2*WIDTH wires.
- SYNC_STAGES, default 2: flip-flop synchronizer depth per rail (minimum 2).

Ports:
- clk  input  1  sole clock
- rst  input  1  reset, asynchronous, active-high
- result_dr  input  2*WIDTH  dual-rail ALU result; bit i uses [2i+1] = true rail, [2i] = false rail
- overflow_dr  input  2  dual-rail overflow; [1] = true rail, [0] = false rail
- ko  output  1  NCL acknowledge: 1 = request DATA, 0 = request NULL
- out_valid  output  1  captured word available
- out_ready  input  1  consumer accepts the word
- out_result  output  WIDTH  single-rail result (true rails)
- out_overflow  output  1  captured overflow
- out_zero  output  1  out_result == 0
- out_negative  output  1  out_result[WIDTH-1]
- err_illegal  output  1  sticky; any sampled rail pair was 2'b11

## Operation
- Every rail of result_dr and overflow_dr passes through a SYNC_STAGES synchronizer; call the output s.
- Per-bit codes: 2'b00 NULL, 2'b01 DATA0, 2'b10 DATA1, 2'b11 illegal.
- complete_data: all WIDTH+1 pairs are DATA. complete_null: all pairs are NULL.
- stable: s equals the previous cycle's s.
- States:
  - REQ_NULL (ko=0): when complete_null && stable, go to REQ_DATA.
  - REQ_DATA (ko=1): when complete_data && stable, latch out_result, out_overflow, out_zero and out_negative, and go to HOLD.
  - HOLD (ko=1, out_valid=1): when out_valid && out_ready, go to REQ_NULL (ko=0, out_valid=0).
  - ERR (ko=0, out_valid=0): reached from any state on an illegal pair in s. Only rst leaves ERR.
- Partial wavefronts (a mix of NULL and DATA) cause a wait in REQ_DATA and REQ_NULL, with no error.
- In HOLD, input changes are ignored. Output registers change only on capture.
- err_illegal asserts in the same cycle ERR is entered and stays high until rst.

## Timing
- Reset values: state REQ_NULL, ko=0, out_valid=0, out_result=0, out_overflow=0, out_zero=0, out_negative=0, err_illegal=0. All synchronizer flops reset to 0 (NULL).
- Capture latency: inputs settle to DATA before edge k. out_valid is high after edge k+SYNC_STAGES+1. This covers SYNC_STAGES sync edges, one stability edge and one capture edge.
- Handshake: out_valid falls on the edge after the accepting cycle (out_valid && out_ready). ko falls on that same edge.
- ko rises SYNC_STAGES+1 edges after a full NULL settles at the inputs.
- out_ready asserted while out_valid=0 has no effect.
- out_valid never drops without acceptance, except on rst or entry to ERR.
- Fastest accept loop with out_ready tied high: capture edge, accept edge, then NULL-wait, then DATA-wait. Throughput is at most one word per 2*(SYNC_STAGES+1)+1 cycles, plus wavefront delay.
- rst mid-HOLD: out_valid drops immediately (asynchronous reset). The FSM restarts in REQ_NULL, so a stale DATA wavefront is never captured twice.

## Structure
- The shared package ncl_pkg holds:
  - dual-rail code constants DR_NULL=2'b00, DR_0=2'b01, DR_1=2'b10, DR_ILL=2'b11;
  - the state enum {REQ_NULL, REQ_DATA, HOLD, ERR}.
- Sub-module ncl_completion: combinational and parameterized by pair count. It outputs is_data, is_null and is_illegal for a dual-rail vector. It is instantiated once on s.
- The synchronizer, FSM, capture registers and flag logic live in ncl_flag_capture.

## Test plan
- Reset, then drive all-NULL: ko=0 for 3 cycles, then ko=1. All outputs stay 0.
- Drive WIDTH=8 DATA for 8'h80 with overflow=1, out_ready=0:
  - out_valid=1 on the 4th edge;
  - out_result=8'h80, out_overflow=1, out_negative=1, out_zero=0;
  - values held while out_ready stays 0, even if the inputs change.
- Assert out_ready in HOLD: out_valid=0 and ko=0 on the next edge. Return NULL, then DATA for 8'h00: capture with out_zero=1 and out_overflow=0.
- Partial wavefront: release result bits one per cycle over 8 cycles. There is no capture until the final bit plus 3 edges. err_illegal stays 0.
- Force bit 3 to 2'b11: err_illegal=1 and ko=0 sticky. Valid DATA/NULL afterwards produces no out_valid. After rst, err_illegal=0 and normal operation resumes.
- Assert rst while out_valid=1: out_valid=0 immediately. With the DATA still present after release, there is no capture until NULL, then DATA, has been seen.
